// File: rtl/acc_job_scheduler.sv
// Job scheduler for the FIR/matmul/sort accelerator: queues one-hot kernel
// requests, issues them on ap_start, tracks ap_done and the output stream.
module acc_job_scheduler #(
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned LEN_FIR  = 64,
  parameter int unsigned LEN_MAT  = 16,
  parameter int unsigned LEN_SORT = 10,
  parameter int unsigned TMO_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [2:0]              req_kernel,
  output logic                    req_ready,
  output logic                    req_illegal,
  output logic [2:0]              ap_start,
  input  logic                    ap_idle,
  input  logic [2:0]              ap_done,
  input  logic                    sm_tvalid,
  input  logic                    sm_tready,
  input  logic                    sm_tlast,
  output logic                    busy,
  output logic [$clog2(QDEPTH):0] q_count,
  output logic                    done_valid,
  output logic [2:0]              done_kernel,
  output logic [1:0]              done_status,
  output logic [7:0]              done_beats,
  output logic                    irq,
  input  logic                    irq_clr
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] K_FIR  = 3'b001;
  localparam logic [2:0] K_MAT  = 3'b010;
  localparam logic [2:0] K_SORT = 3'b100;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_LEN   = 2'b01;
  localparam logic [1:0] ST_WRONG = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_n;
  logic [2:0]       mem [QDEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [CW-1:0]    count_q, count_n;
  logic [2:0]       cur_q, cur_n;
  logic [2:0]       ap_start_q, ap_start_n;
  logic [7:0]       beats_q, beats_n, beats_inc;
  logic [TMO_W-1:0] wdog_q, wdog_n, wdog_inc;
  logic [1:0]       status_q, status_n;
  logic             done_valid_q, done_valid_n;
  logic [2:0]       done_kernel_q, done_kernel_n;
  logic [1:0]       done_status_q, done_status_n;
  logic [7:0]       done_beats_q, done_beats_n;
  logic             irq_q, irq_n;
  logic             illegal_q, illegal_n;
  logic             onehot, full, push, pop, beat, tmo, finish;
  logic [2:0]       head;
  logic [7:0]       exp_len;

  assign onehot    = (req_kernel == K_FIR) || (req_kernel == K_MAT) || (req_kernel == K_SORT);
  assign full      = (count_q == CW'(QDEPTH));
  assign push      = req_valid && !full && onehot;
  assign head      = mem[rd_ptr_q];
  assign beat      = sm_tvalid && sm_tready;
  assign beats_inc = (&beats_q) ? beats_q : beats_q + 8'd1;
  assign wdog_inc  = wdog_q + TMO_W'(1);
  assign tmo       = &wdog_inc;

  always_comb begin
    exp_len = 8'd0;
    case (cur_q)
      K_FIR:   exp_len = 8'(LEN_FIR);
      K_MAT:   exp_len = 8'(LEN_MAT);
      K_SORT:  exp_len = 8'(LEN_SORT);
      default: exp_len = 8'd0;
    endcase
  end

  // Queue bookkeeping; a pop this cycle never frees a slot for this cycle's push.
  always_comb begin
    wr_ptr_n  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_n  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_n   = count_q;
    if (push && !pop)      count_n = count_q + CW'(1);
    else if (!push && pop) count_n = count_q - CW'(1);
    illegal_n = req_valid && !onehot;
  end

  always_comb begin
    state_n       = state_q;
    cur_n         = cur_q;
    ap_start_n    = ap_start_q;
    beats_n       = beats_q;
    wdog_n        = wdog_q;
    status_n      = status_q;
    done_valid_n  = 1'b0;
    done_kernel_n = done_kernel_q;
    done_status_n = done_status_q;
    done_beats_n  = done_beats_q;
    pop           = 1'b0;
    finish        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && ap_idle) begin
          pop        = 1'b1;
          ap_start_n = head;
          cur_n      = head;
          beats_n    = 8'd0;
          wdog_n     = '0;
          status_n   = ST_OK;
          state_n    = S_START;
        end
      end
      S_START: begin
        wdog_n = wdog_inc;
        if (!ap_idle) begin
          ap_start_n = 3'b000;
          state_n    = S_RUN;
        end
      end
      S_RUN: begin
        wdog_n = wdog_inc;
        if (beat) beats_n = beats_inc;
        if (ap_done != 3'b000 && ap_done != cur_q) status_n = ST_WRONG;
        if (beat && sm_tlast)        finish  = 1'b1;
        else if (ap_done != 3'b000)  state_n = S_DRAIN;
      end
      S_DRAIN: begin
        wdog_n = wdog_inc;
        if (beat) beats_n = beats_inc;
        if (beat && sm_tlast) finish = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Watchdog abort outranks every other completion reason.
    if (state_q != S_IDLE && tmo) begin
      finish     = 1'b1;
      status_n   = ST_TMO;
      ap_start_n = 3'b000;
    end

    if (finish) begin
      if (status_n == ST_OK && beats_n != exp_len) status_n = ST_LEN;
      state_n       = S_IDLE;
      done_valid_n  = 1'b1;
      done_kernel_n = cur_q;
      done_status_n = status_n;
      done_beats_n  = beats_n;
    end

    irq_n = done_valid_n || (irq_q && !irq_clr);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= req_kernel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cur_q         <= 3'b000;
      ap_start_q    <= 3'b000;
      beats_q       <= 8'd0;
      wdog_q        <= '0;
      status_q      <= ST_OK;
      done_valid_q  <= 1'b0;
      done_kernel_q <= 3'b000;
      done_status_q <= ST_OK;
      done_beats_q  <= 8'd0;
      irq_q         <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_n;
      wr_ptr_q      <= wr_ptr_n;
      rd_ptr_q      <= rd_ptr_n;
      count_q       <= count_n;
      cur_q         <= cur_n;
      ap_start_q    <= ap_start_n;
      beats_q       <= beats_n;
      wdog_q        <= wdog_n;
      status_q      <= status_n;
      done_valid_q  <= done_valid_n;
      done_kernel_q <= done_kernel_n;
      done_status_q <= done_status_n;
      done_beats_q  <= done_beats_n;
      irq_q         <= irq_n;
      illegal_q     <= illegal_n;
    end
  end

  assign req_ready   = !full;
  assign req_illegal = illegal_q;
  assign ap_start    = ap_start_q;
  assign busy        = (state_q != S_IDLE);
  assign q_count     = count_q;
  assign done_valid  = done_valid_q;
  assign done_kernel = done_kernel_q;
  assign done_status = done_status_q;
  assign done_beats  = done_beats_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Directed bench for acc_job_scheduler: a hand-driven accelerator model with
// expected values worked out per scenario.
module tb_acc_job_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_kernel = 3'b000;
  logic       req_ready;
  logic       req_illegal;
  logic [2:0] ap_start;
  logic       ap_idle = 1'b1;
  logic [2:0] ap_done = 3'b000;
  logic       sm_tvalid = 1'b0;
  logic       sm_tready = 1'b0;
  logic       sm_tlast = 1'b0;
  logic       busy;
  logic [2:0] q_count;
  logic       done_valid;
  logic [2:0] done_kernel;
  logic [1:0] done_status;
  logic [7:0] done_beats;
  logic       irq;
  logic       irq_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0       = 0;

  acc_job_scheduler #(
    .QDEPTH(4), .LEN_FIR(64), .LEN_MAT(16), .LEN_SORT(10), .TMO_W(7)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_kernel(req_kernel),
    .req_ready(req_ready), .req_illegal(req_illegal),
    .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .busy(busy), .q_count(q_count),
    .done_valid(done_valid), .done_kernel(done_kernel),
    .done_status(done_status), .done_beats(done_beats),
    .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [2:0] k);
    req_valid  = 1'b1;
    req_kernel = k;
    tick();
    req_valid  = 1'b0;
  endtask

  // n handshaked beats, tlast (and optionally irq_clr) on the final one
  task automatic stream(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      sm_tvalid = 1'b1;
      sm_tready = 1'b1;
      sm_tlast  = (i == n - 1);
      irq_clr   = clr && (i == n - 1);
      tick();
    end
    sm_tvalid = 1'b0;
    sm_tready = 1'b0;
    sm_tlast  = 1'b0;
    irq_clr   = 1'b0;
  endtask

  task automatic run_job(input logic [2:0] k, input int n, input logic [2:0] done_code,
                         input logic [1:0] st, input bit clr);
    int w = 0;
    while (ap_start == 3'b000 && w < 20) begin
      tick();
      w++;
    end
    check("issue", 32'(ap_start), 32'(k));
    check("busy", 32'(busy), 1);
    ap_idle = 1'b0;
    tick();
    check("start_fall", 32'(ap_start), 0);
    ap_done = done_code;
    tick();
    ap_done = 3'b000;
    stream(n, clr);
    check("done_valid", 32'(done_valid), 1);
    check("done_kernel", 32'(done_kernel), 32'(k));
    check("done_status", 32'(done_status), 32'(st));
    check("done_beats", 32'(done_beats), 32'(n));
    check("irq_set", 32'(irq), 1);
    ap_idle = 1'b1;
    tick();
    check("done_pulse", 32'(done_valid), 0);
    check("status_hold", 32'(done_status), 32'(st));
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 1);
    check("rst_illegal", 32'(req_illegal), 0);
    check("rst_start", 32'(ap_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_qcount", 32'(q_count), 0);
    check("rst_done", 32'(done_valid), 0);
    check("rst_kernel", 32'(done_kernel), 0);
    check("rst_status", 32'(done_status), 0);
    check("rst_beats", 32'(done_beats), 0);
    check("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    tick();

    // single FIR job
    push(3'b001);
    check("fir_qcount_push", 32'(q_count), 1);
    check("fir_start_lat0", 32'(ap_start), 0);
    tick();
    check("fir_start_lat1", 32'(ap_start), 32'(3'b001));
    check("fir_qcount_pop", 32'(q_count), 0);
    run_job(3'b001, 64, 3'b001, 2'b00, 1'b0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 0);

    // back-to-back: matmul, sort, FIR
    req_valid  = 1'b1;
    req_kernel = 3'b010;
    tick();
    req_kernel = 3'b100;
    tick();
    check("b2b_pushpop", 32'(q_count), 1);
    req_kernel = 3'b001;
    tick();
    req_valid = 1'b0;
    check("b2b_qcount", 32'(q_count), 2);
    run_job(3'b010, 16, 3'b010, 2'b00, 1'b0);
    check("b2b_q_after1", 32'(q_count), 1);
    run_job(3'b100, 10, 3'b100, 2'b00, 1'b0);
    check("b2b_q_after2", 32'(q_count), 0);
    run_job(3'b001, 64, 3'b001, 2'b00, 1'b0);

    // sort job with tlast on beat 9
    push(3'b100);
    run_job(3'b100, 9, 3'b100, 2'b01, 1'b0);

    // wrong done on matmul; irq_clr coincides with completion
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_clr2", 32'(irq), 0);
    push(3'b010);
    run_job(3'b010, 16, 3'b001, 2'b10, 1'b1);
    check("irq_sticky", 32'(irq), 1);

    // fill the queue behind a stalled job, then illegal code, then timeout
    req_valid  = 1'b1;
    req_kernel = 3'b001;
    tick();
    req_kernel = 3'b010;
    tick();
    check("full_issue", 32'(ap_start), 32'(3'b001));
    c0 = cyc;
    req_kernel = 3'b100;
    tick();
    req_kernel = 3'b001;
    tick();
    req_kernel = 3'b010;
    tick();
    check("full_qcount", 32'(q_count), 4);
    check("full_ready", 32'(req_ready), 0);
    req_kernel = 3'b100;
    tick();
    check("full_reject", 32'(q_count), 4);
    check("full_no_illegal", 32'(req_illegal), 0);
    req_kernel = 3'b011;
    tick();
    req_valid = 1'b0;
    check("illegal_pulse", 32'(req_illegal), 1);
    check("illegal_qcount", 32'(q_count), 4);
    tick();
    check("illegal_clear", 32'(req_illegal), 0);
    while (!done_valid && (cyc - c0) < 200) tick();
    check("tmo_done", 32'(done_valid), 1);
    check("tmo_latency", 32'(cyc - c0), 127);
    check("tmo_status", 32'(done_status), 32'(2'b11));
    check("tmo_kernel", 32'(done_kernel), 32'(3'b001));
    check("tmo_beats", 32'(done_beats), 0);
    check("tmo_start_off", 32'(ap_start), 0);
    tick();
    check("tmo_next_issue", 32'(ap_start), 32'(3'b010));
    check("tmo_queue_kept", 32'(q_count), 3);

    // async reset while draining
    ap_idle = 1'b0;
    tick();
    ap_done = 3'b010;
    tick();
    ap_done   = 3'b000;
    sm_tvalid = 1'b1;
    sm_tready = 1'b1;
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_qcount", 32'(q_count), 0);
    check("arst_ready", 32'(req_ready), 1);
    check("arst_start", 32'(ap_start), 0);
    check("arst_status", 32'(done_status), 0);
    check("arst_kernel", 32'(done_kernel), 0);
    check("arst_irq", 32'(irq), 0);
    sm_tvalid = 1'b0;
    sm_tready = 1'b0;
    ap_idle   = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_qcount", 32'(q_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_job_scheduler.md
# acc_job_scheduler

Job scheduler that sits between the CPU-side register/mailbox logic and the three-kernel accelerator (FIR, matmul, sorting). It queues one-hot kernel requests and issues them one at a time on the accelerator's `ap_start`. It then tracks each job through `ap_done` and the output stream, checks the output beat count, and reports a completion record with status and a sticky interrupt. A watchdog aborts jobs that stall.

## Interface
Parameters:
- QDEPTH, 4: request queue depth; power of two, ≥2.
- LEN_FIR, 64: expected output beats for a FIR job.
- LEN_MAT, 16: expected output beats for a matmul job.
- LEN_SORT, 10: expected output beats for a sorting job.
- TMO_W, 16: watchdog counter width; timeout after 2^TMO_W−1 cycles in a job.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  job request valid
- req_kernel  in  3  job select, one-hot: 001 FIR, 010 matmul, 100 sort
- req_ready  out  1  queue can accept (= !full)
- req_illegal  out  1  1-cycle pulse: request with non-one-hot code was dropped
- ap_start  out  3  one-hot start to accelerator (registered)
- ap_idle  in  1  accelerator idle
- ap_done  in  3  accelerator done pulse, one-hot
- sm_tvalid, sm_tready, sm_tlast  in  1 each  accelerator output-stream monitor
- busy  out  1  a job is in flight (state ≠ IDLE)
- q_count  out  log2(QDEPTH)+1  queued jobs
- done_valid  out  1  1-cycle completion pulse
- done_kernel  out  3  kernel of completed job
- done_status  out  2  00 ok, 01 length mismatch, 10 wrong done, 11 timeout
- done_beats  out  8  output beats counted (saturates at 255)
- irq  out  1  sticky; set with done_valid, cleared by irq_clr
- irq_clr  in  1  clear irq (set wins if same cycle)

## Operation
- Queue: FIFO of 3-bit codes, circular pointers with wrap at QDEPTH. Push on req_valid & req_ready & one-hot code. A non-one-hot code is never queued: req_illegal pulses the next cycle, q_count unchanged. req_ready depends only on full; a pop in the same cycle does not create room.
- FSM states: IDLE, START, RUN, DRAIN.
  - IDLE: q_count≠0 & ap_idle → pop head, load ap_start=head, clear beat/watchdog counters → START.
  - START: hold ap_start until ap_idle sampled 0; then ap_start←000 → RUN.
  - RUN: ap_done==current → DRAIN. ap_done nonzero & ≠current → latch status 10 → DRAIN.
  - DRAIN: count beats on sm_tvalid&sm_tready. On a beat with sm_tlast: total (including that beat) ≠ LEN_x and status still 00 → status 01. Emit done_valid → IDLE.
- sm_tlast or beats seen in RUN are counted too; DRAIN is entered on completion of the RUN condition even if tlast already passed, and tlast in RUN completes the job directly.
- Watchdog: increments each cycle in START/RUN/DRAIN. At all-ones: ap_start←000, status 11, done_valid, → IDLE. Queue is preserved.
- Status priority: 11 > 10 > 01.
- Reset mid-job: all state is discarded and the queue is flushed; the accelerator is not re-synchronised by this block.

## Timing
- Reset values: req_ready 1, req_illegal 0, ap_start 000, busy 0, q_count 0, done_valid 0, done_kernel 000, done_status 00, done_beats 0, irq 0.
- Request accepted at edge k, IDLE, ap_idle=1: ap_start high from edge k+1.
- ap_start falls at the edge after the first cycle with ap_idle=0. Minimum width is 1 cycle.
- tlast handshake at edge t in DRAIN: done_valid and done_* valid during cycle t..t+1, and irq=1 from edge t. Next job's ap_start no earlier than edge t+1, and only once ap_idle=1.
- done_kernel/done_status/done_beats hold until the next completion.
- q_count changes on the edge of the push/pop; a simultaneous push and pop leave it unchanged.

## Test plan
- Single FIR: push 001, 64 beats with tlast on 64th → ap_start=001 one cycle after push, done_status 00, done_beats 64, irq 1.
- Back-to-back: push 010,100,001 while busy → q_count 2 after third push; jobs issued in order; three done pulses, kernels 010,100,001.
- Full/illegal: with QDEPTH=4 and the accelerator stalled, push 5 valid requests → req_ready 0 after 4 queued (one in flight). Push 011 → req_illegal pulse, q_count unchanged.
- Length mismatch: sort job, tlast on beat 9 → done_status 01, done_beats 9.
- Wrong done: matmul running, ap_done=001 → done_status 10. Timeout with TMO_W=4, no ap_done → done_valid 15 cycles after START, status 11, next queued job starts.
- Async reset during DRAIN → all outputs at reset values immediately, q_count 0; irq_clr coincident with done_valid leaves irq=1.
